// File: rtl/rv_ctrl_pkg.sv
// Shared control types for the RV32I pipeline: sequencer states, x0 index, major opcodes.
// Pure declarations, no logic; imported by the hazard controller and its comparator.
package rv_ctrl_pkg;

  typedef enum logic [0:0] {
    RUN      = 1'b0,
    MEM_WAIT = 1'b1
  } state_e;

  localparam logic [4:0] REG_X0 = 5'd0;

  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;

  function automatic logic is_mem_op(input logic [6:0] opcode);
    return (opcode == OP_LOAD) || (opcode == OP_STORE);
  endfunction

endpackage

// File: rtl/load_use_detect.sv
// Load-use comparator: flags an ID instruction that reads the register a load in EX will write.
// Purely combinational, zero latency; x0 never matches.
module load_use_detect
  import rv_ctrl_pkg::*;
#(
  parameter int REG_ADDR_W = 5
) (
  input  logic [REG_ADDR_W-1:0] id_rs1_i,
  input  logic [REG_ADDR_W-1:0] id_rs2_i,
  input  logic                  id_uses_rs1_i,
  input  logic                  id_uses_rs2_i,
  input  logic [REG_ADDR_W-1:0] ex_rd_i,
  input  logic                  ex_mem_read_i,
  output logic                  luh_o
);

  logic rd_live;
  logic hit_rs1;
  logic hit_rs2;

  assign rd_live = ex_mem_read_i && (ex_rd_i != REG_ADDR_W'(REG_X0));
  assign hit_rs1 = id_uses_rs1_i && (id_rs1_i == ex_rd_i);
  assign hit_rs2 = id_uses_rs2_i && (id_rs2_i == ex_rd_i);
  assign luh_o   = rd_live && (hit_rs1 || hit_rs2);

endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// Stall/flush sequencer for the 5-stage pipeline; outputs are combinational, only state/counter/fault are flopped.
// HAZARD_PERF_EN adds perf_clr plus saturating stall_cycles / flush_events counters.
module pipeline_hazard_ctrl
  import rv_ctrl_pkg::*;
#(
  parameter int REG_ADDR_W  = 5,
  parameter int MEM_TIMEOUT = 255,
  parameter int TO_W        = 8
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [REG_ADDR_W-1:0] id_rs1,
  input  logic [REG_ADDR_W-1:0] id_rs2,
  input  logic                  id_uses_rs1,
  input  logic                  id_uses_rs2,
  input  logic [REG_ADDR_W-1:0] ex_rd,
  input  logic                  ex_mem_read,
  input  logic                  ex_redirect,
  input  logic                  mem_read,
  input  logic                  mem_write,
  input  logic                  dmem_ready,
  output logic                  pc_stall,
  output logic                  if_id_stall,
  output logic                  if_id_flush,
  output logic                  id_ex_stall,
  output logic                  id_ex_flush,
  output logic                  ex_mem_stall,
  output logic                  mem_wb_bubble,
  output logic                  dmem_req,
  output logic                  mem_fault
`ifdef HAZARD_PERF_EN
  ,
  input  logic                  perf_clr,
  output logic [31:0]           stall_cycles,
  output logic [31:0]           flush_events
`endif
);

  localparam logic [TO_W-1:0] TIMEOUT_CNT = TO_W'(MEM_TIMEOUT);

  state_e          state_q, state_d;
  logic [TO_W-1:0] cnt_q, cnt_d;
  logic            fault_q, fault_d;

  logic mem_acc;
  logic luh;
  logic freeze;
  logic timeout_hit;

  assign mem_acc     = mem_read | mem_write;
  assign timeout_hit = (cnt_q == TIMEOUT_CNT);

  load_use_detect #(
    .REG_ADDR_W(REG_ADDR_W)
  ) u_luh (
    .id_rs1_i     (id_rs1),
    .id_rs2_i     (id_rs2),
    .id_uses_rs1_i(id_uses_rs1),
    .id_uses_rs2_i(id_uses_rs2),
    .ex_rd_i      (ex_rd),
    .ex_mem_read_i(ex_mem_read),
    .luh_o        (luh)
  );

  // Ready beats timeout when both land in the same MEM_WAIT cycle.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    fault_d = fault_q;
    freeze  = 1'b0;
    case (state_q)
      RUN: begin
        if (mem_acc && !dmem_ready) begin
          freeze  = 1'b1;
          state_d = MEM_WAIT;
          cnt_d   = TO_W'(1);
        end
      end
      MEM_WAIT: begin
        if (dmem_ready) begin
          state_d = RUN;
          cnt_d   = '0;
        end else if (timeout_hit) begin
          state_d = RUN;
          cnt_d   = '0;
          fault_d = 1'b1;
        end else begin
          freeze = 1'b1;
          cnt_d  = cnt_q + TO_W'(1);
        end
      end
      default: begin
        state_d = RUN;
        cnt_d   = '0;
      end
    endcase
  end

  // Freeze masks flushes so a held redirect/luh is acted on in the release cycle.
  always_comb begin
    pc_stall      = 1'b0;
    if_id_stall   = 1'b0;
    if_id_flush   = 1'b0;
    id_ex_stall   = 1'b0;
    id_ex_flush   = 1'b0;
    ex_mem_stall  = 1'b0;
    mem_wb_bubble = 1'b0;
    dmem_req      = 1'b0;
    mem_fault     = 1'b0;
    if (rst_n) begin
      dmem_req  = mem_acc;
      mem_fault = fault_q;
      if (freeze) begin
        pc_stall      = 1'b1;
        if_id_stall   = 1'b1;
        id_ex_stall   = 1'b1;
        ex_mem_stall  = 1'b1;
        mem_wb_bubble = 1'b1;
      end else if (ex_redirect) begin
        if_id_flush = 1'b1;
        id_ex_flush = 1'b1;
      end else if (luh) begin
        pc_stall    = 1'b1;
        if_id_stall = 1'b1;
        id_ex_flush = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= RUN;
      cnt_q   <= '0;
      fault_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      fault_q <= fault_d;
    end
  end

`ifdef HAZARD_PERF_EN
  logic [31:0] stall_q, stall_d;
  logic [31:0] flush_q, flush_d;

  always_comb begin
    stall_d = stall_q;
    flush_d = flush_q;
    if (perf_clr) begin
      stall_d = '0;
      flush_d = '0;
    end else begin
      if (pc_stall && (stall_q != '1)) stall_d = stall_q + 32'd1;
      if (if_id_flush && (flush_q != '1)) flush_d = flush_q + 32'd1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_q <= '0;
      flush_q <= '0;
    end else begin
      stall_q <= stall_d;
      flush_q <= flush_d;
    end
  end

  assign stall_cycles = stall_q;
  assign flush_events = flush_q;
`endif

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Randomized + directed bench for pipeline_hazard_ctrl against a cycle-level behavioural model.
// Uses MEM_TIMEOUT=4 so the abort path is reachable quickly.
module tb_pipeline_hazard_ctrl;

  localparam int RW = 5;
  localparam int TO = 4;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic [RW-1:0] id_rs1 = '0, id_rs2 = '0, ex_rd = '0;
  logic          id_uses_rs1 = 1'b0, id_uses_rs2 = 1'b0;
  logic          ex_mem_read = 1'b0, ex_redirect = 1'b0;
  logic          mem_read = 1'b0, mem_write = 1'b0, dmem_ready = 1'b0;
  logic          pc_stall, if_id_stall, if_id_flush, id_ex_stall, id_ex_flush;
  logic          ex_mem_stall, mem_wb_bubble, dmem_req, mem_fault;
`ifdef HAZARD_PERF_EN
  logic          perf_clr = 1'b0;
  logic [31:0]   stall_cycles, flush_events;
  logic [31:0]   m_stalls, m_flushes;
`endif

  int checks = 0;
  int errors = 0;

  // Model state: in a wait, how many frozen cycles this access has used, sticky fault.
  bit   m_wait;
  int   m_frozen;
  bit   m_fault;
  logic [8:0] last;

  pipeline_hazard_ctrl #(
    .REG_ADDR_W (RW),
    .MEM_TIMEOUT(TO),
    .TO_W       (8)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .id_rs1       (id_rs1),
    .id_rs2       (id_rs2),
    .id_uses_rs1  (id_uses_rs1),
    .id_uses_rs2  (id_uses_rs2),
    .ex_rd        (ex_rd),
    .ex_mem_read  (ex_mem_read),
    .ex_redirect  (ex_redirect),
    .mem_read     (mem_read),
    .mem_write    (mem_write),
    .dmem_ready   (dmem_ready),
    .pc_stall     (pc_stall),
    .if_id_stall  (if_id_stall),
    .if_id_flush  (if_id_flush),
    .id_ex_stall  (id_ex_stall),
    .id_ex_flush  (id_ex_flush),
    .ex_mem_stall (ex_mem_stall),
    .mem_wb_bubble(mem_wb_bubble),
    .dmem_req     (dmem_req),
    .mem_fault    (mem_fault)
`ifdef HAZARD_PERF_EN
    ,
    .perf_clr     (perf_clr),
    .stall_cycles (stall_cycles),
    .flush_events (flush_events)
`endif
  );

  always #5 clk = ~clk;

  // Vector order: pc_stall, if_id_stall, if_id_flush, id_ex_stall, id_ex_flush, ex_mem_stall, mem_wb_bubble, dmem_req, mem_fault
  function automatic logic [8:0] model_out();
    bit acc, frz, luh;
    acc = mem_read | mem_write;
    if (!rst_n) return 9'b0;
    if (m_wait) frz = !dmem_ready && (m_frozen < TO);
    else        frz = acc && !dmem_ready;
    luh = ex_mem_read && (int'(ex_rd) != 0) &&
          ((id_uses_rs1 && id_rs1 == ex_rd) || (id_uses_rs2 && id_rs2 == ex_rd));
    if (frz)              return {9'b110101100} | {7'b0, acc, m_fault};
    else if (ex_redirect) return {9'b001010000} | {7'b0, acc, m_fault};
    else if (luh)         return {9'b110010000} | {7'b0, acc, m_fault};
    else                  return {7'b0, acc, m_fault};
  endfunction

  task automatic model_advance(input logic [8:0] e);
    if (!rst_n) begin
      m_wait = 0; m_frozen = 0; m_fault = 0;
`ifdef HAZARD_PERF_EN
      m_stalls = 0; m_flushes = 0;
`endif
      return;
    end
`ifdef HAZARD_PERF_EN
    if (perf_clr) begin
      m_stalls = 0; m_flushes = 0;
    end else begin
      if (e[8] && m_stalls != 32'hFFFF_FFFF) m_stalls++;
      if (e[6] && m_flushes != 32'hFFFF_FFFF) m_flushes++;
    end
`endif
    if (m_wait) begin
      if (dmem_ready) begin
        m_wait = 0; m_frozen = 0;
      end else if (m_frozen >= TO) begin
        m_wait = 0; m_frozen = 0; m_fault = 1;
      end else begin
        m_frozen++;
      end
    end else if ((mem_read | mem_write) && !dmem_ready) begin
      m_wait = 1; m_frozen = 1;
    end
  endtask

  task automatic step(input logic [RW-1:0] rs1, rs2, rd,
                      input bit u1, u2, emr, redir, mr, mw, rdy, input bit rst = 1'b1);
    logic [8:0] exp, act;
    @(negedge clk);
    id_rs1 = rs1; id_rs2 = rs2; ex_rd = rd;
    id_uses_rs1 = u1; id_uses_rs2 = u2; ex_mem_read = emr; ex_redirect = redir;
    mem_read = mr; mem_write = mw; dmem_ready = rdy; rst_n = rst;
`ifdef HAZARD_PERF_EN
    perf_clr = ($urandom_range(0, 15) == 0);
`endif
    #2;
    exp = model_out();
    act = {pc_stall, if_id_stall, if_id_flush, id_ex_stall, id_ex_flush,
           ex_mem_stall, mem_wb_bubble, dmem_req, mem_fault};
    last = act;
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL outputs t=%0t got=%b want=%b", $time, act, exp);
    end
`ifdef HAZARD_PERF_EN
    checks++;
    if (stall_cycles !== m_stalls || flush_events !== m_flushes) begin
      errors++;
      $display("FAIL perf t=%0t got=%0d/%0d want=%0d/%0d", $time,
               stall_cycles, flush_events, m_stalls, m_flushes);
    end
`endif
    model_advance(exp);
  endtask

  task automatic lit(input string name, input logic [8:0] want);
    checks++;
    if (last !== want) begin
      errors++;
      $display("FAIL %s got=%b want=%b", name, last, want);
    end
  endtask

  task automatic idle();
    step(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  initial begin
    m_wait = 0; m_frozen = 0; m_fault = 0;
`ifdef HAZARD_PERF_EN
    m_stalls = 0; m_flushes = 0;
`endif
    // Reset gating: a memory access presented during reset shows nothing.
    step(0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 1'b0);
    lit("reset_gate", 9'b0);
    step(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1'b0);
    idle();
    lit("reset_state", 9'b0);

    // Load-use, then one-cycle only, then x0 destination.
    step(5, 0, 5, 1, 0, 1, 0, 0, 0, 0);
    lit("luh_stall", 9'b110010000);
    idle();
    lit("luh_one_cycle", 9'b0);
    step(0, 0, 0, 1, 0, 1, 0, 0, 0, 0);
    lit("luh_x0", 9'b0);
    step(3, 5, 5, 0, 1, 1, 0, 0, 0, 0);
    lit("luh_rs2", 9'b110010000);

    // Redirect beats load-use.
    step(5, 0, 5, 1, 0, 1, 1, 0, 0, 0);
    lit("redirect_over_luh", 9'b001010000);

    // Three-cycle memory wait, then ready.
    for (int i = 0; i < 3; i++) begin
      step(0, 0, 0, 0, 0, 0, 0, 1, 0, 0);
      lit("mem_wait_freeze", 9'b110101110);
    end
    step(0, 0, 0, 0, 0, 0, 0, 1, 0, 1);
    lit("mem_ready_release", 9'b000000010);
    idle();
    lit("mem_back_to_run", 9'b0);

    // Timeout: four frozen cycles, then release and sticky fault.
    for (int i = 0; i < 4; i++) begin
      step(0, 0, 0, 0, 0, 0, 0, 0, 1, 0);
      lit("timeout_freeze", 9'b110101110);
    end
    step(0, 0, 0, 0, 0, 0, 0, 0, 1, 0);
    lit("timeout_release", 9'b000000010);
    idle();
    lit("fault_set", 9'b000000001);
    idle();
    lit("fault_sticky", 9'b000000001);

    // Redirect held during a wait, acted on in the ready cycle.
    for (int i = 0; i < 2; i++) begin
      step(0, 0, 0, 0, 0, 0, 1, 1, 0, 0);
      lit("redirect_held", 9'b110101111);
    end
    step(0, 0, 0, 0, 0, 0, 1, 1, 0, 1);
    lit("redirect_on_release", 9'b001010011);

    // Reset in the middle of a wait.
    step(0, 0, 0, 0, 0, 0, 0, 1, 0, 0);
    step(0, 0, 0, 0, 0, 0, 0, 1, 0, 0);
    step(0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 1'b0);
    lit("reset_mid_wait", 9'b0);
    idle();
    lit("reset_clears_wait", 9'b0);

    // Randomized traffic with small register ranges so hazards are frequent.
    for (int n = 0; n < 4000; n++) begin
      step(RW'($urandom_range(0, 3)), RW'($urandom_range(0, 3)), RW'($urandom_range(0, 3)),
           1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
           1'($urandom_range(0, 1)), ($urandom_range(0, 5) == 0),
           ($urandom_range(0, 3) == 0), ($urandom_range(0, 5) == 0),
           ($urandom_range(0, 4) == 0), ($urandom_range(0, 599) != 0));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
